// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment bus as seen by a scan decoder, plus the published frame.
// master = display driver / bench side, slave = decoder side.
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   an;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;
   logic                    frame_err;

   modport master (
      output seg, an,
      input  digits_out, digit_err, frame_valid, frame_err
   );

   modport slave (
      input  seg, an,
      output digits_out, digit_err, frame_valid, frame_err
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a scanned 7-segment bus; capture STABLE_CYCLES edges after a dwell starts.
// Frame registered on the completing capture edge; passive monitor with no backpressure.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input logic               clk,
   input logic               rst_n,
   seg7_scan_decoder_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

   state_t                  state;
   logic [6:0]              s_seg, p_seg;
   logic [NUM_DIGITS-1:0]   s_an, p_an;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] wbuf, wbuf_n, digits_q;
   logic [NUM_DIGITS-1:0]   werr, werr_n, seen, seen_n, err_q;
   logic                    fv_q, ferr_q;
   logic                    onehot, changed, capture;
   logic [4:0]              dec;
   logic [CW-1:0]           cnt_inc;

   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] d;
      case (p)
         7'b1111110: d = 5'h00;
         7'b0110000: d = 5'h01;
         7'b1101101: d = 5'h02;
         7'b1111001: d = 5'h03;
         7'b0110011: d = 5'h04;
         7'b1011011: d = 5'h05;
         7'b1011111: d = 5'h06;
         7'b1110000: d = 5'h07;
         7'b1111111: d = 5'h08;
         7'b1111011: d = 5'h09;
         7'b0000000: d = 5'h0F;
         default:    d = 5'h1E;
      endcase
      return d;
   endfunction

   assign onehot  = $onehot(s_an);
   assign changed = ({s_seg, s_an} != {p_seg, p_an});
   assign dec     = decode(s_seg);
   assign cnt_inc = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);

   // The change is seen one edge after it was sampled, so the capture fires one count early.
   always_comb begin
      capture = 1'b0;
      if (onehot) begin
         if (changed)
            capture = (STABLE_CYCLES == 1);
         else if (state != CAPTURED)
            capture = (int'(cnt) + 2 >= STABLE_CYCLES);
      end
   end

   always_comb begin
      wbuf_n = wbuf;
      werr_n = werr;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (s_an[i]) begin
            wbuf_n[4*i +: 4] = dec[3:0];
            werr_n[i]        = dec[4];
         end
      end
      seen_n = seen | s_an;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         s_seg    <= '0;
         s_an     <= '0;
         p_seg    <= '0;
         p_an     <= '0;
         cnt      <= '0;
         wbuf     <= '0;
         werr     <= '0;
         seen     <= '0;
         digits_q <= '0;
         err_q    <= '0;
         fv_q     <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         s_seg <= bus.seg;
         s_an  <= bus.an;
         p_seg <= s_seg;
         p_an  <= s_an;
         fv_q  <= 1'b0;

         if (!onehot) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (changed) begin
            state <= capture ? CAPTURED : SETTLE;
            cnt   <= '0;
         end else if (state != CAPTURED) begin
            state <= capture ? CAPTURED : SETTLE;
            cnt   <= cnt_inc;
         end

         if (capture) begin
            wbuf <= wbuf_n;
            werr <= werr_n;
            if (&seen_n) begin
               seen     <= '0;
               digits_q <= wbuf_n;
               err_q    <= werr_n;
               ferr_q   <= |werr_n;
               fv_q     <= 1'b1;
            end else begin
               seen <= seen_n;
            end
         end
      end
   end

   assign bus.digits_out  = digits_q;
   assign bus.digit_err   = err_q;
   assign bus.frame_valid = fv_q;
   assign bus.frame_err   = ferr_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random dwells against a sample-history model.
module tb_seg7_scan_decoder;
   localparam int N = 4;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

   seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   int n_chk = 0;
   int n_fail = 0;
   int n_fv = 0;

   // Model: a capture happens at an edge when the S most recent samples are identical,
   // one-hot, and the sample just before them differs (the dwell started exactly S edges ago).
   logic [6+N:0]   hist [$];
   logic [3:0]     m_slot [N];
   logic [N-1:0]   m_err;
   logic [N-1:0]   m_seen;
   logic [4*N-1:0] e_dout;
   logic [N-1:0]   e_derr;
   logic           e_fv, e_ferr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ref_decode(input logic [6:0] p, output logic [3:0] code, output logic err);
      code = 4'hE;
      err  = 1'b1;
      if (p == 7'b0) begin
         code = 4'hF;
         err  = 1'b0;
      end
      for (int d = 0; d < 10; d++) begin
         if (p == pat[d]) begin
            code = 4'(d);
            err  = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
      m_err  = '0;
      m_seen = '0;
      e_dout = '0;
      e_derr = '0;
      e_fv   = 1'b0;
      e_ferr = 1'b0;
   endtask

   task automatic model_edge(input logic [6+N:0] x);
      logic [6+N:0] v;
      int           last;
      bit           ok;
      logic [3:0]   code;
      logic         err;
      e_fv = 1'b0;
      last = hist.size() - 1;
      v    = hist[last];
      ok   = $onehot(v[N-1:0]) && (hist[last-S] != v);
      for (int k = 1; k < S; k++) if (hist[last-k] != v) ok = 0;
      if (ok) begin
         ref_decode(v[6+N:N], code, err);
         for (int i = 0; i < N; i++) begin
            if (v[i]) begin
               m_slot[i] = code;
               m_err[i]  = err;
               m_seen[i] = 1'b1;
            end
         end
         if (&m_seen) begin
            for (int i = 0; i < N; i++) e_dout[4*i +: 4] = m_slot[i];
            e_derr = m_err;
            e_ferr = |m_err;
            e_fv   = 1'b1;
            m_seen = '0;
         end
      end
      hist.push_back(x);
      void'(hist.pop_front());
   endtask

   task automatic check_outputs();
      chk("frame_valid", 64'(bus.frame_valid), 64'(e_fv));
      chk("digits_out", 64'(bus.digits_out), 64'(e_dout));
      chk("digit_err", 64'(bus.digit_err), 64'(e_derr));
      chk("frame_err", 64'(bus.frame_err), 64'(e_ferr));
      if (bus.frame_valid) n_fv++;
   endtask

   // Called at a negedge; drives, lets one rising edge pass, checks at the next negedge.
   task automatic tick(input logic [6:0] sg, input logic [N-1:0] a);
      bus.seg = sg;
      bus.an  = a;
      @(posedge clk);
      model_edge({sg, a});
      @(negedge clk);
      check_outputs();
   endtask

   task automatic dwell(input logic [6:0] sg, input logic [N-1:0] a, input int cycles);
      for (int c = 0; c < cycles; c++) tick(sg, a);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.seg = '0;
      bus.an  = '0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs();
   endtask

   task automatic scan(input int d0, input int d1, input int d2, input int d3);
      dwell(pat[d0], 4'b0001, 8);
      dwell(pat[d1], 4'b0010, 8);
      dwell(pat[d2], 4'b0100, 8);
      dwell(pat[d3], 4'b1000, 8);
   endtask

   initial begin
      int         idx;
      logic [6:0] sg;
      logic [N-1:0] a;
      bus.seg = '0;
      bus.an  = '0;
      @(negedge clk);
      do_reset();
      chk("rst_dout", 64'(bus.digits_out), 64'h0);
      chk("rst_fv", 64'(bus.frame_valid), 64'h0);

      n_fv = 0;
      scan(1, 2, 3, 4);
      chk("t1_pulses", 64'(n_fv), 64'd1);
      chk("t1_dout", 64'(bus.digits_out), 64'h4321);
      chk("t1_ferr", 64'(bus.frame_err), 64'h0);

      n_fv = 0;
      dwell(pat[5], 4'b0001, 8);
      dwell(pat[6], 4'b0010, 8);
      dwell(7'b1001001, 4'b0100, 8);
      dwell(pat[9], 4'b1000, 8);
      chk("t2_dout", 64'(bus.digits_out), 64'h9E65);
      chk("t2_derr", 64'(bus.digit_err), 64'b0100);
      chk("t2_ferr", 64'(bus.frame_err), 64'h1);

      n_fv = 0;
      for (int g = 0; g < 5; g++) begin
         dwell(pat[3], 4'b0001, 2);
         dwell(pat[8], 4'b0001, 2);
      end
      dwell(pat[0], 4'b0001, 3);
      chk("t3_nopulse", 64'(n_fv), 64'd0);
      dwell(pat[0], 4'b0001, 5);
      dwell(pat[7], 4'b0010, 8);
      dwell(pat[8], 4'b0100, 8);
      dwell(pat[9], 4'b1000, 8);
      chk("t3_pulses", 64'(n_fv), 64'd1);
      chk("t3_dout", 64'(bus.digits_out), 64'h9870);

      n_fv = 0;
      dwell(pat[1], 4'b0001, 8);
      dwell(pat[2], 4'b0010, 8);
      dwell(pat[5], 4'b0011, 10);
      dwell(pat[5], 4'b0000, 10);
      dwell(pat[3], 4'b0100, 8);
      chk("t4_nopulse", 64'(n_fv), 64'd0);
      dwell(pat[4], 4'b1000, 8);
      chk("t4_pulses", 64'(n_fv), 64'd1);
      chk("t4_dout", 64'(bus.digits_out), 64'h4321);

      n_fv = 0;
      dwell(pat[0], 4'b0001, 8);
      dwell(pat[7], 4'b0010, 8);
      dwell(pat[2], 4'b0100, 8);
      dwell(pat[8], 4'b0010, 8);
      dwell(7'b0000000, 4'b1000, 8);
      chk("t5_dout", 64'(bus.digits_out), 64'hF280);
      chk("t5_derr", 64'(bus.digit_err), 64'h0);
      chk("t5_pulses", 64'(n_fv), 64'd1);

      dwell(pat[6], 4'b0001, 8);
      dwell(pat[6], 4'b0010, 8);
      dwell(pat[6], 4'b0100, 8);
      do_reset();
      chk("t6_rst_dout", 64'(bus.digits_out), 64'h0);
      chk("t6_rst_ferr", 64'(bus.frame_err), 64'h0);
      n_fv = 0;
      dwell(pat[1], 4'b0001, 8);
      dwell(pat[2], 4'b0010, 8);
      dwell(pat[3], 4'b0100, 8);
      chk("t6_nopulse", 64'(n_fv), 64'd0);
      dwell(pat[4], 4'b1000, 8);
      chk("t6_pulses", 64'(n_fv), 64'd1);
      chk("t6_dout", 64'(bus.digits_out), 64'h4321);

      for (int r = 0; r < 400; r++) begin
         idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N-1)) : r % N;
         case ($urandom_range(0, 9))
            8:       sg = 7'b0;
            9:       sg = 7'($urandom);
            default: sg = pat[$urandom_range(0, 9)];
         endcase
         a = ($urandom_range(0, 9) < 8) ? N'(1 << idx) : N'($urandom);
         dwell(sg, a, int'($urandom_range(1, 8)));
         if (r == 200) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse path of the team's BCD-to-7-segment encoder: monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and reconstructs the BCD value of every digit.
- Used for loopback self-check of display drivers and for reading external display modules.
- Qualifies each digit dwell for stability, decodes the segment pattern, and publishes a complete frame once every digit position has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (>=1).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- seg  input  7  segment lines {a,b,c,d,e,f,g}, MSB = a, active-high.
- an  input  NUM_DIGITS  digit enables, active-high; bit i selects digit i.
- digits_out  output  4*NUM_DIGITS  published frame; digit i at [4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit invalid-pattern flag for the published frame.
- frame_valid  output  1  one-cycle pulse when digits_out/digit_err update.
- frame_err  output  1  OR of digit_err, registered with the frame.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low; clk/rst_n as named above.
- Reset (rst_n low at an edge): digits_out=0, digit_err=0, frame_valid=0, frame_err=0. Input sample regs, stability counter, working buffer and seen mask cleared; state=IDLE. Reset mid-dwell or mid-frame discards all partial data.
- Input stage: seg and an registered once (s_seg, s_an) every edge. All decisions use the registered values.
- Decode table (exact match only): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
  - 0000000 (blank) -> 4'hF, no error.
  - Any other pattern -> 4'hE with error bit set.
- State machine:
  - IDLE: s_an not one-hot (zero or multiple bits set). Counter held at 0. Go to SETTLE when s_an becomes one-hot.
  - SETTLE: counter increments each edge while (s_seg,s_an) equals the previous sample. Any change resets counter to 0 and stays in SETTLE, or goes to IDLE if no longer one-hot. When the count reaches STABLE_CYCLES, capture and go to CAPTURED.
  - CAPTURED: hold; at most one capture per dwell. Any change in s_seg or s_an returns to SETTLE (or IDLE if not one-hot) with counter 0.
- Capture timing: inputs change before edge E0 and are then held. Capture takes effect at edge E0+STABLE_CYCLES: the working slot for the selected digit gets the decoded code and error bit, and its seen bit is set.
- Recapture of an already-seen digit within a frame overwrites its working slot. The last capture wins.
- Frame completion: on the capture edge that makes the seen mask all-ones:
  - digits_out/digit_err load the working buffer, including the value just captured.
  - frame_err = OR of the new digit_err.
  - frame_valid is high for exactly the following cycle.
  - seen mask clears on the same edge.
- Outputs hold between frames. A bus that stops scanning never pulses frame_valid.
- Arithmetic: counter width is clog2(STABLE_CYCLES+1) and saturates; no wrap. With NUM_DIGITS=1, every capture completes a frame.

Test Plan:
- Reset, then scan 1,2,3,4 on digits 0..3 (patterns 0110000, 1101101, 1111001, 0110011), 8 cycles/digit, STABLE_CYCLES=4 -> one frame_valid pulse, digits_out=16'h4321, frame_err=0.
- Digit 2 shows 1001001 (invalid) during a scan of 5,6,x,9 -> digits_out=16'h9E65, digit_err=4'b0100, frame_err=1.
- Glitch: seg toggles every 2 cycles while an=0001 for 20 cycles, then stable 0 -> no capture during toggling; capture exactly 4 edges after the last change; slot 0=0.
- an=0011 (two bits) for 10 cycles with a valid pattern -> no capture, seen mask unchanged; an=0000 likewise.
- Digit 1 captured as 7, re-dwelled as 8 before the frame completes -> published digit 1 = 8. Blank on digit 3 -> nibble F, no error.
- Assert rst_n low for one edge after 3 of 4 digits are captured -> all outputs 0. Next full scan needs all 4 digits before frame_valid.
